count_sequencer: RTL

Control stage directly upstream of the 4-bit down-counter. It accepts a start request with a load value and drives the counter's `latch`, `in` and `dec` inputs: it loads the counter, then issues exactly as many decrement pulses as the load value, optionally at half rate. It then checks the counter's `zero` flag, reports completion, and keeps a count of completed runs.

---
 rtl/count_seq_pkg.sv | 6 +
 rtl/dec_pacer.sv | 38 +++
 rtl/count_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding and default widths for the count sequencer
package count_seq_pkg;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_RUNS_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;
endpackage

// File: rtl/dec_pacer.sv
// dec_pacer: shadow down-counter that paces decrement strobes at full or half rate
module dec_pacer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             div2,
  output logic             dec,
  output logic             last
);
  logic [WIDTH-1:0] r_cnt;
  logic             r_ph;
  logic             r_dec;
  logic             w_fire;
  // r_ph marks the idle half-cycle after a strobe in half-rate mode
  assign w_fire = (r_cnt != '0) && !r_ph;
  assign last   = (r_cnt == '0) && !r_ph;
  assign dec    = r_dec;
  // the shadow count is consumed as each strobe is scheduled, so dec is a clean register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_ph  <= 1'b0;
      r_dec <= 1'b0;
    end else if (load) begin
      r_cnt <= load_val;
      r_ph  <= 1'b0;
      r_dec <= 1'b0;
    end else if (en) begin
      r_dec <= w_fire;
      r_cnt <= r_cnt - WIDTH'(w_fire);
      r_ph  <= div2 & w_fire;
    end else
      r_dec <= 1'b0;
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: loads the down-counter, paces its decrements and checks its zero flag
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int RUNS_W = DEF_RUNS_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              div2,
  input  logic              abort,
  input  logic              zero,
  output logic              latch,
  output logic [WIDTH-1:0]  cnt_in,
  output logic              dec,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [RUNS_W-1:0] runs
);
  state_t            r_state;
  logic              r_latch;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_div2;
  logic [WIDTH-1:0]  r_cnt_in;
  logic [RUNS_W-1:0] r_runs;
  logic              w_load;
  logic              w_en;
  logic              w_last;
  assign w_load = (r_state == IDLE) && start;
  assign w_en   = ((r_state == SETTLE) || (r_state == RUN)) && !abort;
  assign latch  = r_latch;
  assign cnt_in = r_cnt_in;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign runs   = r_runs;
  dec_pacer #(.WIDTH(WIDTH)) u_pacer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (w_load),
    .load_val (load_val),
    .en       (w_en),
    .div2     (r_div2),
    .dec      (dec),
    .last     (w_last)
  );
  // run sequencing; every output is set on the edge entering the state that shows it
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state  <= IDLE;
      r_latch  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_div2   <= 1'b0;
      r_cnt_in <= '0;
      r_runs   <= '0;
    end else begin
      r_latch <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state  <= LOAD;
          r_latch  <= 1'b1;
          r_busy   <= 1'b1;
          r_cnt_in <= load_val;
          r_div2   <= div2;
        end
        LOAD: begin
          r_state <= abort ? IDLE : SETTLE;
          r_busy  <= !abort;
        end
        SETTLE, RUN: if (abort) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else if (w_last) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_runs  <= r_runs + RUNS_W'(1);
        end else
          r_state <= RUN;
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_err   <= r_err | !zero;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
endmodule
